rf_riscv_mp: RTL and testbench

//   Parametrised multi-port integer register file with a built-in write scoreboard.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_riscv_mp_if.sv | 36 +++
 rtl/rf_scoreboard.sv | 57 +++++
 rtl/rf_riscv_mp.sv | 89 ++++++++
 tb/tb_rf_riscv_mp.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types, defaults and helpers for the multi-port register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]          xlen_t;

    // One-hot decode of a register address (bit a set).
    function automatic logic [NREGS_DEF-1:0] onehot_dec(input reg_addr_t a);
        return NREGS_DEF'(1) << a;
    endfunction

endpackage

// File: rtl/rf_riscv_mp_if.sv
// Bundle of read, write and reservation signals between the core and the
// register file. The core drives through the master modport; the register
// file responds through the slave modport.
interface rf_riscv_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [NWR-1:0]      wr_en_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic                rsv_en_i;
    logic [AW-1:0]       rsv_addr_i;
    logic                rsv_ok_o;
    logic [NREGS-1:0]    busy_o;
    logic [AW:0]         outstanding_o;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        input  rd_data_o, rd_busy_o, rsv_ok_o, busy_o, outstanding_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        output rd_data_o, rd_busy_o, rsv_ok_o, busy_o, outstanding_o
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Write scoreboard: one busy bit per register, reservation acceptance and a
// registered count of outstanding (busy) registers. Register 0 is never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREGS-1:0] rel_i,        // registers written this cycle (bit 0 always 0)
    input  logic             rsv_en_i,
    input  logic [AW-1:0]    rsv_addr_i,
    output logic             rsv_ok_o,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      outstanding_o
);

    logic [NREGS-1:0] busy_q, busy_d, set_vec;
    logic [AW:0]      cnt_q, cnt_d;

    function automatic logic [AW:0] popcnt(input logic [NREGS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++) n = n + {{AW{1'b0}}, v[i]};
        return n;
    endfunction

    // Accept a reservation when the target is free or being released now;
    // the new owner wins over a same-cycle release.
    always_comb begin
        rsv_ok_o = rsv_en_i & ((rsv_addr_i == '0) | !busy_q[rsv_addr_i] | rel_i[rsv_addr_i]);
        set_vec  = '0;
        if (rsv_ok_o && rsv_addr_i != '0)
            set_vec = NREGS'(onehot_dec(reg_addr_t'(rsv_addr_i)));
        busy_d = (busy_q & ~rel_i) | set_vec;
        // Count only real transitions so a same-cycle release+reserve is net zero.
        cnt_d  = cnt_q + popcnt(set_vec & ~busy_q) - popcnt(busy_q & rel_i & ~set_vec);
    end

    // Busy vector and outstanding counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the comb block above uses blocking on purpose.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign outstanding_o = cnt_q;

endmodule

// File: rtl/rf_riscv_mp.sv
// Multi-port integer register file with write scoreboard for a dual-issue core.
// NRD combinational read ports, NWR synchronous write ports, r0 hardwired to 0.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to reads.
module rf_riscv_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    rf_riscv_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     mem_q  [NREGS];
    logic [XLEN-1:0]     wr_val [NREGS];
    logic [NREGS-1:0]    wr_hit;
    logic [NREGS-1:0]    busy;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    // Resolve write ports per register; a higher port overrides a lower one.
    // r0 is never flagged, so writes to it vanish and never release it.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
        end
        for (int i = 1; i < NREGS; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.wr_en_i[p] && bus.wr_addr_i[p*AW +: AW] == AW'(i)) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = bus.wr_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Storage array commit.
    // NOTE: the array is reset because the reset state is architecturally
    // visible (all registers read 0); that rules out a RAM macro here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++)
                if (wr_hit[i]) mem_q[i] <= wr_val[i];
        end
    end

    // Read muxes; r0 stays 0 because it is never written and never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*XLEN +: XLEN] = mem_q[bus.rd_addr_i[k*AW +: AW]];
            rd_busy[k]              = busy[bus.rd_addr_i[k*AW +: AW]];
`ifdef RF_BYPASS_EN
            if (wr_hit[bus.rd_addr_i[k*AW +: AW]]) begin
                rd_data[k*XLEN +: XLEN] = wr_val[bus.rd_addr_i[k*AW +: AW]];
                rd_busy[k] = bus.rsv_en_i && (bus.rsv_addr_i == bus.rd_addr_i[k*AW +: AW]);
            end
`endif
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rel_i         (wr_hit),
        .rsv_en_i      (bus.rsv_en_i),
        .rsv_addr_i    (bus.rsv_addr_i),
        .rsv_ok_o      (bus.rsv_ok_o),
        .busy_o        (busy),
        .outstanding_o (bus.outstanding_o)
    );

    assign bus.busy_o    = busy;
    assign bus.rd_data_o = rd_data;
    assign bus.rd_busy_o = rd_busy;

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Directed bench for rf_riscv_mp. Stimulus pushes expected observations into
// a queue; a monitor pops and compares them when outputs are sampled.
module tb_rf_riscv_mp;
    import rf_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = $clog2(NREGS);

    typedef enum int {K_RD_DATA, K_RD_BUSY, K_BUSY, K_OUTST, K_RSV_OK} kind_e;
    typedef struct {
        kind_e kind;
        int    port;
        xlen_t val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    event ev_sample;

    rf_riscv_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    rf_riscv_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) -> ev_sample;

    task automatic check(input string name, input xlen_t act, input xlen_t want_v);
        n_checks++;
        if (act !== want_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want_v);
        end
    endtask

    task automatic want(input kind_e k, input int p, input xlen_t v, input string n);
        exp_t e;
        e.kind = k;
        e.port = p;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.wr_en_i    = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.rsv_en_i   = 1'b0;
        bus.rsv_addr_i = '0;
        bus.rd_addr_i  = '0;
    endtask

    task automatic wr(input int p, input int a, input xlen_t d);
        bus.wr_en_i[p]                 = 1'b1;
        bus.wr_addr_i[p*AW +: AW]      = AW'(a);
        bus.wr_data_i[p*XLEN +: XLEN]  = d;
    endtask

    task automatic rsv(input int a);
        bus.rsv_en_i   = 1'b1;
        bus.rsv_addr_i = AW'(a);
    endtask

    task automatic rd(input int k, input int a);
        bus.rd_addr_i[k*AW +: AW] = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: compare every queued expectation against the sampled outputs.
    initial begin : monitor
        exp_t  e;
        xlen_t act;
        forever begin
            @(ev_sample);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_RD_DATA: act = bus.rd_data_o[e.port*XLEN +: XLEN];
                    K_RD_BUSY: act = xlen_t'(bus.rd_busy_o[e.port]);
                    K_BUSY:    act = xlen_t'(bus.busy_o);
                    K_OUTST:   act = xlen_t'(bus.outstanding_o);
                    default:   act = xlen_t'(bus.rsv_ok_o);
                endcase
                check(e.name, act, e.val);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        rd(0, 5);
        want(K_RD_DATA, 0, 32'h0, "rst_r5");
        want(K_BUSY,    0, 32'h0, "rst_busy");
        want(K_OUTST,   0, 32'h0, "rst_outst");
        tick();

        // 1: reset mid-operation
        wr(0, 5, 32'hDEAD_BEEF);
        rsv(6);
        want(K_RSV_OK, 0, 32'h1, "t1_rsv_ok");
        tick();
        rd(0, 5);
        want(K_RD_DATA, 0, 32'hDEAD_BEEF, "t1_r5_before");
        want(K_BUSY,    0, 32'h40,        "t1_busy_before");
        want(K_OUTST,   0, 32'h1,         "t1_outst_before");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        want(K_RD_DATA, 0, 32'h0, "t1_r5_async");
        want(K_BUSY,    0, 32'h0, "t1_busy_async");
        want(K_OUTST,   0, 32'h0, "t1_outst_async");
        -> ev_sample;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        rd(0, 5);
        want(K_RD_DATA, 0, 32'h0, "t1_r5_after");
        tick();

        // 2: write port conflict and r0 writes
        wr(0, 3, 32'h11);
        wr(1, 3, 32'h22);
        tick();
        rd(0, 3);
        want(K_RD_DATA, 0, 32'h22, "t2_r3_hi_port");
        wr(0, 0, 32'hFFFF_FFFF);
        wr(1, 0, 32'hFFFF_FFFF);
        tick();
        rd(0, 3);
        rd(1, 0);
        want(K_RD_DATA, 0, 32'h22, "t2_r3_hold");
        want(K_RD_DATA, 1, 32'h0,  "t2_r0_zero");
        want(K_RD_BUSY, 1, 32'h0,  "t2_r0_busy");
        tick();

        // 3: scoreboard reserve / reject / release
        rsv(7);
        want(K_RSV_OK, 0, 32'h1, "t3_rsv_ok");
        tick();
        rsv(7);
        rd(0, 7);
        want(K_RSV_OK,  0, 32'h0,  "t3_rsv_reject");
        want(K_BUSY,    0, 32'h80, "t3_busy_set");
        want(K_OUTST,   0, 32'h1,  "t3_outst_one");
        want(K_RD_BUSY, 0, 32'h1,  "t3_rd_busy");
        want(K_RD_DATA, 0, 32'h0,  "t3_stale_data");
        tick();
        want(K_BUSY,  0, 32'h80, "t3_busy_unchanged");
        want(K_OUTST, 0, 32'h1,  "t3_outst_unchanged");
        wr(0, 7, 32'h5A);
        tick();
        rd(0, 7);
        want(K_RD_DATA, 0, 32'h5A, "t3_r7_data");
        want(K_RD_BUSY, 0, 32'h0,  "t3_rd_busy_clr");
        want(K_BUSY,    0, 32'h0,  "t3_busy_clr");
        want(K_OUTST,   0, 32'h0,  "t3_outst_zero");
        tick();

        // 4: release and reservation of the same register in one cycle
        rsv(7);
        tick();
        wr(0, 7, 32'h99);
        rsv(7);
        want(K_RSV_OK, 0, 32'h1,  "t4_rsv_ok");
        want(K_OUTST,  0, 32'h1,  "t4_outst_pre");
        tick();
        rd(0, 7);
        want(K_RD_DATA, 0, 32'h99, "t4_r7_data");
        want(K_RD_BUSY, 0, 32'h1,  "t4_rd_busy");
        want(K_BUSY,    0, 32'h80, "t4_busy_kept");
        want(K_OUTST,   0, 32'h1,  "t4_outst_kept");
        wr(0, 7, 32'h99);
        tick();
        want(K_OUTST, 0, 32'h0, "t4_outst_clr");
        rsv(0);
        want(K_RSV_OK, 0, 32'h1, "t4_rsv_r0_ok");
        tick();
        want(K_BUSY,  0, 32'h0, "t4_r0_not_busy");
        want(K_OUTST, 0, 32'h0, "t4_r0_no_count");
        tick();

        // 5: same-cycle read of a register being written
        wr(0, 9, 32'h55);
        tick();
        wr(1, 9, 32'h1234);
        rd(0, 9);
`ifdef RF_BYPASS_EN
        want(K_RD_DATA, 0, 32'h1234, "t5_bypass_data");
`else
        want(K_RD_DATA, 0, 32'h55,   "t5_stale_data");
`endif
        want(K_RD_BUSY, 0, 32'h0, "t5_rd_busy");
        tick();
        rd(0, 9);
        want(K_RD_DATA, 0, 32'h1234, "t5_next_cycle");
        tick();

        // 6: saturation and drain two per cycle
        for (int i = 1; i < NREGS; i++) begin
            rsv(i);
            want(K_RSV_OK, 0, 32'h1, $sformatf("t6_rsv_r%0d", i));
            tick();
        end
        want(K_OUTST, 0, 32'd31,        "t6_outst_full");
        want(K_BUSY,  0, 32'hFFFF_FFFE, "t6_busy_full");
        for (int k = 0; k < 16; k++) begin
            want(K_OUTST, 0, xlen_t'(31 - 2*k), $sformatf("t6_drain_%0d", k));
            wr(0, 2*k + 1, xlen_t'(k));
            if (2*k + 2 < NREGS) wr(1, 2*k + 2, xlen_t'(k));
            tick();
        end
        want(K_OUTST, 0, 32'h0, "t6_outst_empty");
        want(K_BUSY,  0, 32'h0, "t6_busy_empty");
        tick();

        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
